axis_bram_writer: RTL and testbench

Consumes the 32-bit AXI4-Stream words produced by the AXI4-Lite-to-stream writer stage and stores them sequentially into a block-RAM port. It is used to load waveform and lookup tables from the processor. It runs a small run/load/done state machine with one-shot and circular modes, and reports write pointer, wrap count and dropped-word count. The upstream stage has no back-pressure, so this block accepts a word on every cycle that `s_axis_tvalid` is high and never stalls.

---
 rtl/axis_bram_writer.sv | 229 ++++++++++++++++++++++
 tb/tb_axis_bram_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_writer.sv
// -----------------------------------------------------------------------------
// axis_bram_writer
//
// Stores a free-running 32-bit AXI4-Stream into a block-RAM write port, one
// word per address, starting at address 0. Used to load waveform and lookup
// tables from the processor. The upstream stage cannot be stalled, so every
// cycle with s_axis_tvalid high is consumed: the word is written while the
// loader is in LOAD, or discarded and counted while it is not.
//
// Control is a three-state machine (IDLE -> LOAD -> DONE). A rising edge on
// cfg_run starts a pass: the length and mode are captured, the pointer and
// status counters are cleared. In one-shot mode the block stops in DONE after
// cfg_length words; in circular mode it rewrites the same region forever and
// counts completed passes. Dropping cfg_run aborts a load or leaves DONE.
//
// Parameters
//   AXIS_TDATA_WIDTH  stream data width
//   BRAM_DATA_WIDTH   BRAM word width (<= AXIS_TDATA_WIDTH, low bits are kept)
//   BRAM_ADDR_WIDTH   BRAM address width, depth D = 2**BRAM_ADDR_WIDTH
//
// Ports
//   aclk               system clock
//   areset             synchronous, active-high reset
//   cfg_run            level control; rising edge starts, low aborts/idles
//   cfg_length         words per pass, 0..D, captured at start
//   cfg_wrap           1 = circular, 0 = one-shot, captured at start
//   s_axis_tdata       stream data
//   s_axis_tvalid      stream valid (no tready; never back-pressured)
//   bram_porta_clk     BRAM clock, same as aclk
//   bram_porta_rst     BRAM reset, same as areset
//   bram_porta_addr    registered write address
//   bram_porta_wrdata  registered write data
//   bram_porta_we      registered write enable
//   sts_addr           next address to be written
//   sts_done           high while in DONE
//   sts_wraps          completed circular passes, modulo 2**16
//   sts_dropped        words discarded outside LOAD, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module axis_bram_writer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
) (
  input  logic                         aclk,
  input  logic                         areset,

  input  logic                         cfg_run,
  input  logic [BRAM_ADDR_WIDTH:0]     cfg_length,
  input  logic                         cfg_wrap,

  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,

  output logic                         bram_porta_clk,
  output logic                         bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
  output logic                         bram_porta_we,

  output logic [BRAM_ADDR_WIDTH-1:0]   sts_addr,
  output logic                         sts_done,
  output logic [15:0]                  sts_wraps,
  output logic [15:0]                  sts_dropped
);

  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int DW = BRAM_DATA_WIDTH;

  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   LEN_ZERO  = '0;
  localparam logic [15:0]   CNT_ONE   = 16'd1;
  localparam logic [15:0]   CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            run_q;       // cfg_run from the previous cycle
  logic [AW:0]     len_q;       // pass length captured at start
  logic            wrap_q;      // mode captured at start
  logic [AW-1:0]   ptr;         // next address to write

  logic            start;
  logic            accept;
  logic            last_word;
  logic            drop;

  // The BRAM port shares this block's clock and reset.
  assign bram_porta_clk = aclk;
  assign bram_porta_rst = areset;

  // A start is a rising edge of cfg_run. run_q resets to 0, so a level that
  // is already high when reset is released counts as a start.
  assign start = cfg_run & ~run_q;

  // In LOAD every valid word is written, including the word that arrives in
  // the same cycle cfg_run falls. A start never coincides with LOAD (cfg_run
  // low always leaves LOAD), but the guard keeps start's clear unambiguous.
  assign accept = (state == ST_LOAD) && s_axis_tvalid && !start;

  // The last word of a pass sits at len_q-1. len_q is never 0 in LOAD, and
  // for len_q = D the comparison is against D-1, so full depth needs no
  // special case.
  assign last_word = accept && ({1'b0, ptr} == (len_q - LEN_ONE));

  // Words outside LOAD are discarded; the start cycle clears the counter
  // instead of counting its own word.
  assign drop = (state != ST_LOAD) && s_axis_tvalid && !start;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_next
    // unassigned and a latch is never inferred.
    state_next = state;

    if (start) begin
      // A zero-length pass has nothing to write and finishes immediately.
      state_next = (cfg_length == LEN_ZERO) ? ST_DONE : ST_LOAD;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_next = ST_IDLE;
        end
        ST_LOAD: begin
          // Abort takes priority over reaching the end of a one-shot pass.
          if (!cfg_run) begin
            state_next = ST_IDLE;
          end else if (last_word && !wrap_q) begin
            state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          if (!cfg_run) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Run-edge detector, captured configuration and write pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      run_q  <= 1'b0;
      len_q  <= '0;
      wrap_q <= 1'b0;
      ptr    <= '0;
    end else begin
      run_q <= cfg_run;

      if (start) begin
        len_q  <= cfg_length;
        wrap_q <= cfg_wrap;
        ptr    <= '0;
      end else if (accept) begin
        // The pointer returns to 0 after the last word in either mode; in
        // one-shot mode the held value is then simply not used again.
        ptr <= last_word ? '0 : (ptr + ADDR_ONE);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // BRAM write port: one registered write per accepted word
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      bram_porta_we     <= 1'b0;
      bram_porta_addr   <= '0;
      bram_porta_wrdata <= '0;
    end else begin
      bram_porta_we <= accept;
      if (accept) begin
        bram_porta_addr   <= ptr;
        bram_porta_wrdata <= s_axis_tdata[DW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      sts_wraps   <= '0;
      sts_dropped <= '0;
    end else if (start) begin
      sts_wraps   <= '0;
      sts_dropped <= '0;
    end else begin
      if (last_word && wrap_q) begin
        sts_wraps <= sts_wraps + CNT_ONE;
      end
      if (drop && (sts_dropped != CNT_MAX)) begin
        sts_dropped <= sts_dropped + CNT_ONE;
      end
    end
  end

  assign sts_addr = ptr;
  assign sts_done = (state == ST_DONE);

endmodule

// File: tb/tb_axis_bram_writer.sv
// -----------------------------------------------------------------------------
// tb_axis_bram_writer
//
// Directed bench for axis_bram_writer with default parameters (32-bit data,
// 1024-word BRAM). Inputs change 1 ns after a rising edge and outputs are
// sampled at that same point, so each check sees the registers loaded by the
// edge just before it.
// -----------------------------------------------------------------------------
module tb_axis_bram_writer;

  localparam int AXIS_TDATA_WIDTH = 32;
  localparam int BRAM_DATA_WIDTH  = 32;
  localparam int BRAM_ADDR_WIDTH  = 10;

  logic                         aclk;
  logic                         areset;
  logic                         cfg_run;
  logic [BRAM_ADDR_WIDTH:0]     cfg_length;
  logic                         cfg_wrap;
  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata;
  logic                         s_axis_tvalid;
  logic                         bram_porta_clk;
  logic                         bram_porta_rst;
  logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr;
  logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata;
  logic                         bram_porta_we;
  logic [BRAM_ADDR_WIDTH-1:0]   sts_addr;
  logic                         sts_done;
  logic [15:0]                  sts_wraps;
  logic [15:0]                  sts_dropped;

  int vectors;
  int miscompares;

  axis_bram_writer #(
    .AXIS_TDATA_WIDTH (AXIS_TDATA_WIDTH),
    .BRAM_DATA_WIDTH  (BRAM_DATA_WIDTH),
    .BRAM_ADDR_WIDTH  (BRAM_ADDR_WIDTH)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .cfg_run           (cfg_run),
    .cfg_length        (cfg_length),
    .cfg_wrap          (cfg_wrap),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .bram_porta_clk    (bram_porta_clk),
    .bram_porta_rst    (bram_porta_rst),
    .bram_porta_addr   (bram_porta_addr),
    .bram_porta_wrdata (bram_porta_wrdata),
    .bram_porta_we     (bram_porta_we),
    .sts_addr          (sts_addr),
    .sts_done          (sts_done),
    .sts_wraps         (sts_wraps),
    .sts_dropped       (sts_dropped)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One valid word for one cycle; consecutive calls give back-to-back words.
  task automatic push(input logic [31:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_we"},   32'(bram_porta_we),     32'd1);
    check({tag, "_addr"}, 32'(bram_porta_addr),   addr);
    check({tag, "_data"}, 32'(bram_porta_wrdata), data);
  endtask

  initial begin
    int bad;
    vectors       = 0;
    miscompares   = 0;
    areset        = 1'b1;
    cfg_run       = 1'b0;
    cfg_length    = '0;
    cfg_wrap      = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;

    // ---- reset state ------------------------------------------------------
    tick();
    tick();
    check("rst_we",      32'(bram_porta_we),     32'd0);
    check("rst_addr",    32'(bram_porta_addr),   32'd0);
    check("rst_wrdata",  32'(bram_porta_wrdata), 32'd0);
    check("rst_sts_addr",32'(sts_addr),          32'd0);
    check("rst_done",    32'(sts_done),          32'd0);
    check("rst_wraps",   32'(sts_wraps),         32'd0);
    check("rst_dropped", 32'(sts_dropped),       32'd0);
    check("rst_pass",    32'(bram_porta_rst),    32'd1);
    areset = 1'b0;
    tick();

    // ---- one-shot load, length 4 -----------------------------------------
    cfg_length = 11'd4;
    cfg_wrap   = 1'b0;
    cfg_run    = 1'b1;
    tick();                                   // start edge
    check("os_start_we",   32'(bram_porta_we), 32'd0);
    check("os_start_done", 32'(sts_done),      32'd0);
    for (int i = 0; i < 4; i++) begin
      push(32'hA0 + 32'(i));
      check_write("os_w", 32'(i), 32'hA0 + 32'(i));
      check("os_done", 32'(sts_done), (i == 3) ? 32'd1 : 32'd0);
    end
    check("os_sts_addr", 32'(sts_addr), 32'd0);
    push(32'hA4);                             // fifth word: dropped in DONE
    check("os_drop_we",  32'(bram_porta_we), 32'd0);
    check("os_dropped",  32'(sts_dropped),   32'd1);
    check("os_hold_done",32'(sts_done),      32'd1);
    cfg_run = 1'b0;
    tick();
    check("os_idle_done",32'(sts_done),      32'd0);

    // ---- circular load, length 3, 7 words --------------------------------
    cfg_length = 11'd3;
    cfg_wrap   = 1'b1;
    cfg_run    = 1'b1;
    tick();
    check("circ_dropped_clr", 32'(sts_dropped), 32'd0);
    for (int i = 0; i < 7; i++) begin
      push(32'h100 + 32'(i));
      check_write("circ_w", 32'(i % 3), 32'h100 + 32'(i));
    end
    check("circ_wraps",    32'(sts_wraps), 32'd2);
    check("circ_done",     32'(sts_done),  32'd0);
    check("circ_sts_addr", 32'(sts_addr),  32'd1);
    // A length change during LOAD must not affect the running pass.
    cfg_length = 11'd5;
    push(32'h107);
    check_write("circ_len_ignored", 32'd1, 32'h107);
    push(32'h108);
    check_write("circ_wrap3", 32'd2, 32'h108);
    check("circ_wraps3", 32'(sts_wraps), 32'd3);
    cfg_run = 1'b0;
    tick();

    // ---- zero length ------------------------------------------------------
    cfg_length = 11'd0;
    cfg_wrap   = 1'b0;
    cfg_run    = 1'b1;
    tick();
    check("zero_done",  32'(sts_done),      32'd1);
    check("zero_we",    32'(bram_porta_we), 32'd0);
    check("zero_wraps", 32'(sts_wraps),     32'd0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      push(32'h200 + 32'(i));
      if (bram_porta_we !== 1'b0) bad++;
    end
    check("zero_no_writes", 32'(bad),         32'd0);
    check("zero_dropped",   32'(sts_dropped), 32'd3);
    cfg_run = 1'b0;
    tick();

    // ---- full depth, circular, 1025 words ---------------------------------
    cfg_length = 11'd1024;
    cfg_wrap   = 1'b1;
    cfg_run    = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 1025; i++) begin
      push(32'(i) ^ 32'h5A5A0000);
      if (bram_porta_we !== 1'b1 || 32'(bram_porta_addr) !== (32'(i) % 32'd1024) ||
          bram_porta_wrdata !== (32'(i) ^ 32'h5A5A0000)) bad++;
      if (i == 1023) begin
        check("full_addr_last", 32'(bram_porta_addr), 32'd1023);
        check("full_wraps_1",   32'(sts_wraps),       32'd1);
      end
    end
    check("full_seq_bad",   32'(bad),             32'd0);
    check("full_addr_wrap", 32'(bram_porta_addr), 32'd0);
    check("full_wraps",     32'(sts_wraps),       32'd1);
    check("full_sts_addr",  32'(sts_addr),        32'd1);
    cfg_run = 1'b0;
    tick();

    // ---- dropped-counter saturation in IDLE --------------------------------
    bad = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hDEAD;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (bram_porta_we !== 1'b0) bad++;
    end
    s_axis_tvalid = 1'b0;
    check("sat_no_writes", 32'(bad),         32'd0);
    check("sat_dropped",   32'(sts_dropped), 32'hFFFF);

    // ---- abort and restart -----------------------------------------------
    cfg_length    = 11'd8;
    cfg_wrap      = 1'b0;
    cfg_run       = 1'b1;
    s_axis_tvalid = 1'b1;                     // word coincident with start
    s_axis_tdata  = 32'hEE;
    tick();
    s_axis_tvalid = 1'b0;
    check("ab_start_we",      32'(bram_porta_we), 32'd0);
    check("ab_start_dropped", 32'(sts_dropped),   32'd0);
    push(32'hB0);
    check_write("ab_w0", 32'd0, 32'hB0);
    push(32'hB1);
    check_write("ab_w1", 32'd1, 32'hB1);
    cfg_run = 1'b0;                           // abort with a word in the same cycle
    push(32'hB2);
    check_write("ab_w2", 32'd2, 32'hB2);
    tick();
    check("ab_idle_we",    32'(bram_porta_we), 32'd0);
    check("ab_sts_addr",   32'(sts_addr),      32'd3);
    check("ab_done",       32'(sts_done),      32'd0);
    check("ab_dropped",    32'(sts_dropped),   32'd0);
    cfg_run = 1'b1;                           // restart
    tick();
    check("rs_sts_addr", 32'(sts_addr), 32'd0);
    push(32'hC0);
    check_write("rs_w0", 32'd0, 32'hC0);
    push(32'hC1);
    check_write("rs_w1", 32'd1, 32'hC1);

    // ---- reset mid-LOAD ---------------------------------------------------
    areset        = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hFF;
    tick();
    check("mr_we",       32'(bram_porta_we),     32'd0);
    check("mr_addr",     32'(bram_porta_addr),   32'd0);
    check("mr_wrdata",   32'(bram_porta_wrdata), 32'd0);
    check("mr_sts_addr", 32'(sts_addr),          32'd0);
    check("mr_done",     32'(sts_done),          32'd0);
    check("mr_wraps",    32'(sts_wraps),         32'd0);
    check("mr_dropped",  32'(sts_dropped),       32'd0);
    tick();
    check("mr_we2",      32'(bram_porta_we),     32'd0);
    // cfg_run stays high: the first cycle out of reset must be a start.
    areset        = 1'b0;
    s_axis_tvalid = 1'b0;
    tick();
    check("mr_post_we",  32'(bram_porta_we), 32'd0);
    push(32'hD0);
    check_write("mr_restart_w0", 32'd0, 32'hD0);
    check("mr_restart_dropped", 32'(sts_dropped), 32'd0);
    cfg_run = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
